// File: rtl/dbg_abstract_cmd.sv
// Abstract-command executor for RISC-V Debug "Access Register" commands.
// Validates a launched command, performs one 32-bit GPR/CSR bus access and reports cmderr.
module dbg_abstract_cmd #(
  parameter int TIMEOUT   = 64,
  parameter int GPR_COUNT = 32
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCmd_valid,
  input  logic [31:0] iCmd,
  input  logic [31:0] iData0,
  input  logic        iHalted,
  output logic        oBusy,
  output logic        oDone,
  output logic [2:0]  oCmderr,
  output logic        oData0_we,
  output logic [31:0] oData0,
  output logic        oRegno_inc,
  output logic        oBus_valid,
  output logic        oBus_csr,
  output logic        oBus_write,
  output logic [11:0] oBus_addr,
  output logic [31:0] oBus_wdata,
  input  logic        iBus_ready,
  input  logic [31:0] iBus_rdata,
  input  logic        iBus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0]  ERR_NONE   = 3'd0;
  localparam logic [2:0]  ERR_NOTSUP = 3'd2;
  localparam logic [2:0]  ERR_EXC    = 3'd3;
  localparam logic [2:0]  ERR_HALT   = 3'd4;
  localparam logic [15:0] GPR_BASE   = 16'h1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched command fields
  logic [7:0]  cmdtype_q, cmdtype_d;
  logic [2:0]  aarsize_q, aarsize_d;
  logic        postinc_q, postinc_d;
  logic        postexec_q, postexec_d;
  logic        transfer_q, transfer_d;
  logic        write_q, write_d;
  logic [15:0] regno_q, regno_d;
  logic [31:0] data0_q, data0_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered outputs
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        inc_q, inc_d;
  logic        bvalid_q, bvalid_d;
  logic        bcsr_q, bcsr_d;
  logic        bwrite_q, bwrite_d;
  logic [11:0] baddr_q, baddr_d;
  logic [31:0] bwdata_q, bwdata_d;

  // Bit 23 of an Access Register command is reserved and carries no meaning here.
  logic cmd_rsvd_unused;
  assign cmd_rsvd_unused = iCmd[23];

  logic        regno_is_csr;
  logic        regno_is_gpr;
  logic [15:0] gpr_off;

  assign regno_is_csr = (regno_q < GPR_BASE);
  assign gpr_off      = regno_q - GPR_BASE;
  assign regno_is_gpr = !regno_is_csr && (gpr_off < 16'(GPR_COUNT));

  logic       fin;
  logic [2:0] fin_err;

  always_comb begin
    state_d    = state_q;
    cmdtype_d  = cmdtype_q;
    aarsize_d  = aarsize_q;
    postinc_d  = postinc_q;
    postexec_d = postexec_q;
    transfer_d = transfer_q;
    write_d    = write_q;
    regno_d    = regno_q;
    data0_d    = data0_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cmderr_d   = ERR_NONE;
    we_d       = 1'b0;
    rdata_d    = rdata_q;
    inc_d      = 1'b0;
    bvalid_d   = bvalid_q;
    bcsr_d     = bcsr_q;
    bwrite_d   = bwrite_q;
    baddr_d    = baddr_q;
    bwdata_d   = bwdata_q;
    fin        = 1'b0;
    fin_err    = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (iCmd_valid) begin
          cmdtype_d  = iCmd[31:24];
          aarsize_d  = iCmd[22:20];
          postinc_d  = iCmd[19];
          postexec_d = iCmd[18];
          transfer_d = iCmd[17];
          write_d    = iCmd[16];
          regno_d    = iCmd[15:0];
          data0_d    = iData0;
          busy_d     = 1'b1;
          state_d    = S_CHECK;
        end
      end

      S_CHECK: begin
        // Rule order matters: the first matching rule decides cmderr.
        if (cmdtype_q != 8'd0) begin
          fin     = 1'b1;
          fin_err = ERR_NOTSUP;
        end else if (postexec_q) begin
          fin     = 1'b1;
          fin_err = ERR_NOTSUP;
        end else if (transfer_q && (aarsize_q != 3'd2)) begin
          fin     = 1'b1;
          fin_err = ERR_NOTSUP;
        end else if (!iHalted) begin
          fin     = 1'b1;
          fin_err = ERR_HALT;
        end else if (transfer_q && !regno_is_csr && !regno_is_gpr) begin
          fin     = 1'b1;
          fin_err = ERR_EXC;
        end else if (!transfer_q) begin
          fin     = 1'b1;
          fin_err = ERR_NONE;
        end else begin
          state_d  = S_REQ;
          cnt_d    = '0;
          bvalid_d = 1'b1;
          bcsr_d   = regno_is_csr;
          bwrite_d = write_q;
          baddr_d  = regno_is_csr ? regno_q[11:0] : gpr_off[11:0];
          bwdata_d = data0_q;
        end
      end

      S_REQ: begin
        if (iBus_ready) begin
          fin     = 1'b1;
          fin_err = iBus_err ? ERR_EXC : ERR_NONE;
          if (!iBus_err && !write_q) begin
            rdata_d = iBus_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = ERR_EXC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Common completion path: report, release the bus, post-increment on success.
    if (fin) begin
      state_d  = S_DONE;
      done_d   = 1'b1;
      cmderr_d = fin_err;
      we_d     = (fin_err == ERR_NONE) && transfer_q && !write_q;
      inc_d    = (fin_err == ERR_NONE) && postinc_q;
      bvalid_d = 1'b0;
      bcsr_d   = 1'b0;
      bwrite_d = 1'b0;
      baddr_d  = '0;
      bwdata_d = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      cmdtype_q  <= '0;
      aarsize_q  <= '0;
      postinc_q  <= 1'b0;
      postexec_q <= 1'b0;
      transfer_q <= 1'b0;
      write_q    <= 1'b0;
      regno_q    <= '0;
      data0_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmderr_q   <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      inc_q      <= 1'b0;
      bvalid_q   <= 1'b0;
      bcsr_q     <= 1'b0;
      bwrite_q   <= 1'b0;
      baddr_q    <= '0;
      bwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cmdtype_q  <= cmdtype_d;
      aarsize_q  <= aarsize_d;
      postinc_q  <= postinc_d;
      postexec_q <= postexec_d;
      transfer_q <= transfer_d;
      write_q    <= write_d;
      regno_q    <= regno_d;
      data0_q    <= data0_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmderr_q   <= cmderr_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      inc_q      <= inc_d;
      bvalid_q   <= bvalid_d;
      bcsr_q     <= bcsr_d;
      bwrite_q   <= bwrite_d;
      baddr_q    <= baddr_d;
      bwdata_q   <= bwdata_d;
    end
  end

  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oCmderr    = cmderr_q;
  assign oData0_we  = we_q;
  assign oData0     = rdata_q;
  assign oRegno_inc = inc_q;
  assign oBus_valid = bvalid_q;
  assign oBus_csr   = bcsr_q;
  assign oBus_write = bwrite_q;
  assign oBus_addr  = baddr_q;
  assign oBus_wdata = bwdata_q;

endmodule

// File: doc/dbg_abstract_cmd.md
Name: dbg_abstract_cmd

Overview:
- Abstract-command executor sitting directly downstream of the debug module's command register.
- Accepts one RISC-V Debug 1.0 "Access Register" command per launch, validates it, and performs a single 32-bit GPR or CSR access over a valid/ready bus master.
- Returns read data for data0, a cmderr code, and a post-increment request back to the debug module; drives abstractcs.busy.

Parameters:
- TIMEOUT, 64, cycles to wait for iBus_ready before aborting with an exception error (legal range 2..1023).
- GPR_COUNT, 32, number of implemented GPRs mapped at regno 0x1000..0x1000+GPR_COUNT-1.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  synchronous reset, active-high.
- iCmd_valid  in  1  one-cycle launch strobe (command register written while not busy).
- iCmd  in  32  command word: [31:24] cmdtype, [22:20] aarsize, [19] aarpostincrement, [18] postexec, [17] transfer, [16] write, [15:0] regno.
- iData0  in  32  data0 value, sampled at launch.
- iHalted  in  1  hart halted status.
- oBusy  out  1  command in progress (abstractcs.busy).
- oDone  out  1  one-cycle completion pulse.
- oCmderr  out  3  error code, valid with oDone.
- oData0_we  out  1  one-cycle data0 write strobe (successful reads only).
- oData0  out  32  read data for data0.
- oRegno_inc  out  1  one-cycle strobe: increment command.regno.
- oBus_valid  out  1  bus request valid.
- oBus_csr  out  1  1 = CSR target, 0 = register file.
- oBus_write  out  1  bus write.
- oBus_addr  out  12  CSR address, or GPR index in [4:0].
- oBus_wdata  out  32  write data.
- iBus_ready  in  1  bus accepts/completes the request (single-cycle handshake).
- iBus_rdata  in  32  read data, valid when iBus_ready.
- iBus_err  in  1  access fault, valid when iBus_ready.

Behaviour:
- Reset (iRst sampled high at a clock edge): state IDLE; all outputs 0; timeout counter 0. Reset mid-command aborts it with no oDone pulse; any outstanding bus request is dropped.
- States: IDLE, CHECK, REQ, DONE.
- IDLE: on iCmd_valid, latch iCmd and iData0; assert oBusy from the next cycle; go to CHECK.
- CHECK (1 cycle): first matching rule wins:
  - cmdtype!=0 -> err 2.
  - postexec=1 -> err 2 (no program buffer).
  - transfer=1 and aarsize!=2 -> err 2.
  - iHalted=0 -> err 4.
  - transfer=1 and regno outside [0x0000..0x0FFF] ∪ [0x1000..0x1000+GPR_COUNT-1] -> err 3.
  - Any error goes to DONE.
  - transfer=0 -> DONE with err 0 and no bus access.
  - Otherwise go to REQ.
- REQ: drive oBus_valid=1 with csr=(regno<0x1000), write, addr, wdata held stable until iBus_ready.
  - On iBus_ready: deassert valid that cycle. iBus_err=1 -> err 3. Else err 0, and on a read capture iBus_rdata. Go to DONE.
  - Counter counts cycles in REQ; when it reaches TIMEOUT without ready, drop valid and go to DONE with err 3.
- DONE (1 cycle): pulse oDone with oCmderr.
  - oData0_we=1 only for a successful read (transfer=1, write=0, err 0).
  - oRegno_inc=1 when aarpostincrement=1 and err 0, including transfer=0. regno arithmetic is 16-bit wrap, performed by the debug module.
  - oBusy drops the following cycle; return to IDLE.
- Latency: transfer=0 command gives launch-to-oDone 2 cycles. Bus access gives 3 + (REQ cycles − 1).
- iCmd_valid while oBusy=1: ignored; the active command is undisturbed. Busy-error reporting belongs to the debug module.
- iHalted falling during REQ: the access completes normally; halted status is checked only in CHECK.
- oBus_addr for a GPR is regno−0x1000, zero-extended to 12 bits.

Test Plan:
- Halted, iCmd=0x0022_1001 (read x1), bus ready after 2 cycles with rdata 0xDEADBEEF -> oData0_we pulse, oData0=0xDEADBEEF, oCmderr=0, oBus_csr=0, addr=1.
- Halted, iCmd=0x0023_0300 (write mstatus), iData0=0x1888 -> bus write csr=1 addr=0x300 wdata=0x1888; oDone with err 0; no oData0_we.
- Not halted, iCmd=0x0022_1002 -> oDone err 4, no oBus_valid. cmdtype=1 -> err 2. aarsize=3 -> err 2. regno 0x1020 -> err 3.
- iCmd=0x002A_1005 (postincrement read) -> oRegno_inc pulses with oDone. iCmd=0x0008_0000 (transfer=0, postinc) -> oDone after 2 cycles, err 0, oRegno_inc=1.
- iBus_ready held low -> oBus_valid held exactly TIMEOUT cycles, then err 3. iBus_err=1 with ready -> err 3, no oData0_we.
- Second iCmd_valid while busy -> ignored. iRst asserted during REQ -> next cycle all outputs 0, no oDone.
